// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, stall/flush controls out.
// Optional PIPE_HAZARD_PERF_EN adds the 32-bit performance counter outputs.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs_i;
    logic [4:0]  id_rt_i;
    logic        id_uses_rt_i;
    logic        ex_memread_i;
    logic [4:0]  ex_rt_i;
    logic        branch_taken_i;
    logic        mem_req_i;
    logic        mem_ack_i;
    logic        pc_write_o;
    logic        ifid_write_o;
    logic        ifid_flush_o;
    logic        idex_bubble_o;
    logic        back_hold_o;
    logic [1:0]  state_o;
    logic        err_o;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
    logic [31:0] memwait_cnt_o;
`endif

    modport master (
`ifdef PIPE_HAZARD_PERF_EN
        input  stall_cnt_o, flush_cnt_o, memwait_cnt_o,
`endif
        output id_rs_i, id_rt_i, id_uses_rt_i,
        output ex_memread_i, ex_rt_i, branch_taken_i,
        output mem_req_i, mem_ack_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o,
        input  idex_bubble_o, back_hold_o, state_o, err_o
    );

    modport slave (
`ifdef PIPE_HAZARD_PERF_EN
        output stall_cnt_o, flush_cnt_o, memwait_cnt_o,
`endif
        input  id_rs_i, id_rt_i, id_uses_rt_i,
        input  ex_memread_i, ex_rt_i, branch_taken_i,
        input  mem_req_i, mem_ack_i,
        output pc_write_o, ifid_write_o, ifid_flush_o,
        output idex_bubble_o, back_hold_o, state_o, err_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: memory wait > load-use > taken branch.
// Define PIPE_HAZARD_PERF_EN to add stall/flush/memwait cycle counters.
module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT       = 255
) (
    input logic               clk_i,
    input logic               rst_i,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        BAD      = 2'd3
    } state_t;

    localparam logic [3:0]  LU_LOAD = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [15:0] TMO     = 16'(MEM_TIMEOUT);

    state_t      state, state_nxt;
    state_t      prior, prior_nxt;
    state_t      eff;
    logic [3:0]  lu_cnt, lu_cnt_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic        err, err_nxt;
    logic        memstall, loaduse, frozen;
    logic        pc_write, ifid_write, ifid_flush;
    logic        idex_bubble, back_hold;

    assign memstall = hz.mem_req_i & ~hz.mem_ack_i;
    assign loaduse  = hz.ex_memread_i & (hz.ex_rt_i != 5'd0) &
                      ((hz.ex_rt_i == hz.id_rs_i) |
                       (hz.id_uses_rt_i & (hz.ex_rt_i == hz.id_rt_i)));
    assign frozen   = memstall | ((state == MEM_WAIT) & ~hz.mem_ack_i);
    // On ack the wait cycle behaves like the state that was interrupted
    assign eff      = (state == MEM_WAIT) ? prior : state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= RUN;
            prior    <= RUN;
            lu_cnt   <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            prior    <= prior_nxt;
            lu_cnt   <= lu_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        prior_nxt    = prior;
        lu_cnt_nxt   = lu_cnt;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = err;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        back_hold    = 1'b0;
        if (frozen) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            back_hold  = 1'b1;
            state_nxt  = MEM_WAIT;
            if (state != MEM_WAIT)
                prior_nxt = (state == LU_STALL) ? LU_STALL : RUN;
            if (wait_cnt != TMO)
                wait_cnt_nxt = wait_cnt + 16'd1;
            if (wait_cnt_nxt == TMO)
                err_nxt = 1'b1;
        end else begin
            wait_cnt_nxt = '0;
            unique case (1'b1)
                eff == LU_STALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    lu_cnt_nxt  = lu_cnt - 4'd1;
                    state_nxt   = (lu_cnt == 4'd1) ? RUN : LU_STALL;
                end
                eff == RUN && loaduse: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_nxt   = RUN;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_nxt  = LU_STALL;
                        lu_cnt_nxt = LU_LOAD;
                    end
                end
                eff == RUN && !loaduse && hz.branch_taken_i: begin
                    ifid_flush = 1'b1;
                    state_nxt  = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign hz.pc_write_o    = pc_write;
    assign hz.ifid_write_o  = ifid_write;
    assign hz.ifid_flush_o  = ifid_flush;
    assign hz.idex_bubble_o = idex_bubble;
    assign hz.back_hold_o   = back_hold;
    assign hz.state_o       = state;
    assign hz.err_o         = err;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, memwait_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            memwait_cnt <= '0;
        end else begin
            if (!pc_write)
                stall_cnt <= stall_cnt + 32'd1;
            if (ifid_flush)
                flush_cnt <= flush_cnt + 32'd1;
            if (state == MEM_WAIT)
                memwait_cnt <= memwait_cnt + 32'd1;
        end
    end

    assign hz.stall_cnt_o   = stall_cnt;
    assign hz.flush_cnt_o   = flush_cnt;
    assign hz.memwait_cnt_o = memwait_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (1 and 3 stall cycles, timeouts
// 255 and 3) driven alike and checked against a bubble-count model.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs, rt, ert;
    logic       urt, mr, br, rq, ak;

    int tests = 0;
    int fails = 0;

    // obs/exp layout: {pc_write, ifid_write, flush, bubble, hold, state[1:0], err}
    logic [7:0] exp_v;
    int lsc[2]   = '{1, 3};
    int tmo[2]   = '{255, 3};
    int m_left[2];
    int m_fc[2];
    bit m_wait[2];
    bit m_err[2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus[2]();

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        assign bus[g].id_rs_i        = rs;
        assign bus[g].id_rt_i        = rt;
        assign bus[g].id_uses_rt_i   = urt;
        assign bus[g].ex_memread_i   = mr;
        assign bus[g].ex_rt_i        = ert;
        assign bus[g].branch_taken_i = br;
        assign bus[g].mem_req_i      = rq;
        assign bus[g].mem_ack_i      = ak;
        pipe_hazard_ctrl #(
            .LOAD_STALL_CYCLES(g == 0 ? 1 : 3),
            .MEM_TIMEOUT      (g == 0 ? 255 : 3)
        ) u_dut (
            .clk_i(clk),
            .rst_i(rst),
            .hz   (bus[g])
        );
    end

    function automatic logic [7:0] obs(input int k);
        if (k == 0)
            return {bus[0].pc_write_o, bus[0].ifid_write_o, bus[0].ifid_flush_o,
                    bus[0].idex_bubble_o, bus[0].back_hold_o, bus[0].state_o,
                    bus[0].err_o};
        return {bus[1].pc_write_o, bus[1].ifid_write_o, bus[1].ifid_flush_o,
                bus[1].idex_bubble_o, bus[1].back_hold_o, bus[1].state_o,
                bus[1].err_o};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0;
            m_fc[k]   = 0;
            m_wait[k] = 1'b0;
            m_err[k]  = 1'b0;
        end
    endfunction

    // Expected outputs for this cycle, then advance the model one clock
    function automatic void model_step(input int k);
        bit ms, lu;
        ms = rq && !ak;
        lu = mr && (ert != 0) && (ert == rs || (urt && ert == rt));
        exp_v = 8'b1100_0000;
        exp_v[2:1] = m_wait[k] ? 2'd2 : (m_left[k] > 0 ? 2'd1 : 2'd0);
        exp_v[0] = m_err[k];
        if (ms || (m_wait[k] && !ak)) begin
            exp_v[7:3] = 5'b00001;
            m_wait[k] = 1'b1;
            if (m_fc[k] < tmo[k]) m_fc[k]++;
            if (m_fc[k] == tmo[k]) m_err[k] = 1'b1;
        end else begin
            m_wait[k] = 1'b0;
            m_fc[k] = 0;
            if (m_left[k] > 0) begin
                exp_v[7:3] = 5'b00010;
                m_left[k]--;
            end else if (lu) begin
                exp_v[7:3] = 5'b00010;
                m_left[k] = lsc[k] - 1;
            end else if (br) begin
                exp_v[7:3] = 5'b11100;
            end
        end
    endfunction

    task automatic drive(input logic [4:0] a_rs, a_rt, input logic a_urt,
                         input logic a_mr, input logic [4:0] a_ert,
                         input logic a_br, a_rq, a_ak);
        rs = a_rs; rt = a_rt; urt = a_urt; mr = a_mr;
        ert = a_ert; br = a_br; rq = a_rq; ak = a_ak;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            model_step(k);
            tests++;
            if (obs(k) !== 8'b1100_0000) begin
                fails++;
                $display("FAIL reset dut%0d: got %b want 11000000", k, obs(k));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        int nb0, nb1;
        for (int p = 0; p < 2; p++) begin
            nb0 = 0; nb1 = 0;
            for (int c = 0; c < 5; c++) begin
                if (c == 0) drive(8, 3, 0, 1, (p == 0) ? 5'd8 : 5'd0, 0, 0, 0);
                else        drive(0, 0, 0, 0, 0, 0, 0, 0);
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    model_step(k);
                    tests++;
                    if (obs(k) !== exp_v) begin
                        fails++;
                        $display("FAIL load_use p%0d dut%0d c%0d: got %b want %b",
                                 p, k, c, obs(k), exp_v);
                    end
                end
                if (c < 4 && bus[1].state_o !== ((p == 0 && c inside {1, 2}) ? 2'd1 : 2'd0)) begin
                    fails++;
                    $display("FAIL lu_state_seq p%0d c%0d: got %0d", p, c, bus[1].state_o);
                end
                tests++;
                nb0 += int'(bus[0].idex_bubble_o);
                nb1 += int'(bus[1].idex_bubble_o);
                @(posedge clk); #1;
            end
            tests++;
            if (nb0 != ((p == 0) ? 1 : 0) || nb1 != ((p == 0) ? 3 : 0)) begin
                fails++;
                $display("FAIL lu_bubbles p%0d: got %0d/%0d", p, nb0, nb1);
            end
        end
    endtask

    task automatic test_branch();
        for (int c = 0; c < 6; c++) begin
            unique case (c)
                0:       drive(0, 0, 0, 0, 0, 1, 0, 0);
                3:       drive(4, 9, 1, 1, 9, 1, 0, 0);
                default: drive(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                model_step(k);
                tests++;
                if (obs(k) !== exp_v) begin
                    fails++;
                    $display("FAIL branch dut%0d c%0d: got %b want %b",
                             k, c, obs(k), exp_v);
                end
            end
            tests++;
            if (bus[0].ifid_flush_o !== (c == 0)) begin
                fails++;
                $display("FAIL branch_flush c%0d: got %b", c, bus[0].ifid_flush_o);
            end
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                model_step(k);
                tests++;
                if (obs(k) !== exp_v) begin
                    fails++;
                    $display("FAIL branch_drain dut%0d: got %b want %b", k, obs(k), exp_v);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        int nh;
        nh = 0;
        for (int c = 0; c < 7; c++) begin
            if (c < 4)       drive(0, 0, 0, 0, 0, 0, 1, 0);
            else if (c == 4) drive(0, 0, 0, 0, 0, 0, 1, 1);
            else             drive(0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                model_step(k);
                tests++;
                if (obs(k) !== exp_v) begin
                    fails++;
                    $display("FAIL mem_wait dut%0d c%0d: got %b want %b",
                             k, c, obs(k), exp_v);
                end
            end
            tests++;
            if (bus[1].err_o !== (c >= 3) || bus[0].err_o !== 1'b0) begin
                fails++;
                $display("FAIL mem_err c%0d: got %b/%b", c, bus[0].err_o, bus[1].err_o);
            end
            nh += int'(bus[0].back_hold_o);
            @(posedge clk); #1;
        end
        tests++;
        if (nh != 4) begin
            fails++;
            $display("FAIL mem_hold_count: got %0d want 4", nh);
        end
    endtask

    task automatic test_rst_mid();
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 4; c++) begin
                if (p == 0) drive(7, 0, 0, (c == 0), 7, 0, 0, 0);
                else        drive(0, 0, 0, 0, 0, 0, 1, 0);
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    model_step(k);
                    tests++;
                    if (obs(k) !== exp_v) begin
                        fails++;
                        $display("FAIL rst_mid_pre p%0d dut%0d c%0d: got %b want %b",
                                 p, k, c, obs(k), exp_v);
                    end
                end
                @(posedge clk); #1;
                if (c == 0 && p == 0) break;
            end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            model_reset();
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                model_step(k);
                tests++;
                if (obs(k) !== 8'b1100_0000) begin
                    fails++;
                    $display("FAIL rst_mid p%0d dut%0d: got %b want 11000000",
                             p, k, obs(k));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 2),
                  ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 5));
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                model_step(k);
                tests++;
                if (obs(k) !== exp_v) begin
                    fails++;
                    $display("FAIL random dut%0d c%0d: got %b want %b",
                             k, c, obs(k), exp_v);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
